// File: rtl/ysyx_25010008_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, valid/ready hand-off downstream.
// Optional performance counters are enabled by defining YSYX_25010008_IFU_PERF_EN.
module ysyx_25010008_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] FAULT_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_fault,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
`ifdef YSYX_25010008_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {StAr, StR, StOut, StWait} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fault_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StAr;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAr: begin
          if (arready) state_q <= StR;
        end
        StR: begin
          if (rvalid) begin
            inst_q  <= (rresp == 2'b00) ? rdata : FAULT_INST;
            fault_q <= (rresp != 2'b00);
            state_q <= StOut;
          end
        end
        StOut: begin
          if (inst_ready) state_q <= StWait;
        end
        StWait: begin
          if (npc_valid) begin
            pc_q    <= npc;
            state_q <= StAr;
          end
        end
        default: state_q <= StAr;
      endcase
    end
  end

  // Handshakes are masked while reset is held so nothing is offered during the reset cycle.
  assign arvalid    = (state_q == StAr) && !reset;
  assign rready     = (state_q == StR) && !reset;
  assign inst_valid = (state_q == StOut) && !reset;
  assign araddr     = {pc_q[31:2], 2'b00};
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_fault = fault_q;

`ifdef YSYX_25010008_IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == StOut && inst_ready) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if ((state_q == StAr && !arready) || (state_q == StR && !rvalid)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25010008_ifu.sv
// Self-checking bench for ysyx_25010008_ifu: directed corner cases plus randomized fetches
// against a transaction-level model (expected pc, instruction word, fault and counters).
module tb_ysyx_25010008_ifu;

  localparam logic [31:0] ResetPc   = 32'h8000_0000;
  localparam logic [31:0] FaultInst = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] npc = '0;
  logic        npc_valid = 1'b0;
  logic [31:0] inst, pc, araddr;
  logic        inst_fault, inst_valid, arvalid, rready;
  logic        inst_ready = 1'b0;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
`ifdef YSYX_25010008_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] exp_pc;
  int unsigned exp_fetches;
  int unsigned exp_stalls;

  ysyx_25010008_ifu dut (
    .clock     (clock),
    .reset     (reset),
    .npc       (npc),
    .npc_valid (npc_valid),
    .inst      (inst),
    .pc        (pc),
    .inst_fault(inst_fault),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready)
`ifdef YSYX_25010008_IFU_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf();
`ifdef YSYX_25010008_IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, exp_fetches);
    chk("perf_stall", perf_stall_cnt, exp_stalls);
`endif
  endtask

  // Holds reset for two cycles, then releases it; returns inside the first cycle with reset low.
  task automatic do_reset();
    reset = 1'b1; arready = 1'b0; rvalid = 1'b0; inst_ready = 1'b0; npc_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    end
    reset = 1'b0;
    #1;
    exp_pc = ResetPc; exp_fetches = 0; exp_stalls = 0;
    chk("rst_inst", inst, 32'd0);
    chk("rst_fault", 32'(inst_fault), 32'd0);
    chk("rst_pc", pc, ResetPc);
    chk("rel_arvalid", 32'(arvalid), 32'd1);
    chk("rel_araddr", araddr, ResetPc);
    chk_perf();
  endtask

  // One whole fetch starting in the address phase; ends in the wait-for-npc phase.
  task automatic fetch(input int ar_d, input int r_d, input logic [1:0] resp,
                       input logic [31:0] data, input int rdy_d);
    logic [31:0] exp_inst;
    exp_inst = (resp == 2'b00) ? data : FaultInst;
    for (int i = 0; i <= ar_d; i++) begin
      arready = (i == ar_d); #1;
      chk("ar_arvalid", 32'(arvalid), 32'd1);
      chk("ar_araddr", araddr, {exp_pc[31:2], 2'b00});
      chk("ar_rready", 32'(rready), 32'd0);
      chk("ar_inst_valid", 32'(inst_valid), 32'd0);
      @(negedge clock);
    end
    arready = 1'b0;
    for (int i = 0; i <= r_d; i++) begin
      rvalid = (i == r_d);
      rdata  = (i == r_d) ? data : $urandom;
      rresp  = (i == r_d) ? resp : 2'($urandom);
      #1;
      chk("r_rready", 32'(rready), 32'd1);
      chk("r_arvalid", 32'(arvalid), 32'd0);
      chk("r_inst_valid", 32'(inst_valid), 32'd0);
      @(negedge clock);
    end
    rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
    for (int i = 0; i <= rdy_d; i++) begin
      inst_ready = (i == rdy_d);
      npc_valid  = (i != rdy_d) && (i % 2 == 0);
      npc        = $urandom;
      #1;
      chk("out_inst_valid", 32'(inst_valid), 32'd1);
      chk("out_inst", inst, exp_inst);
      chk("out_pc", pc, exp_pc);
      chk("out_fault", 32'(inst_fault), 32'(resp != 2'b00));
      chk("out_arvalid", 32'(arvalid), 32'd0);
      @(negedge clock);
    end
    inst_ready = 1'b0; npc_valid = 1'b0;
    exp_fetches++;
    exp_stalls += ar_d + r_d;
  endtask

  // In the wait phase: idle wait_d cycles, then present the next pc.
  task automatic give_npc(input int wait_d, input logic [31:0] next);
    for (int i = 0; i <= wait_d; i++) begin
      npc_valid = (i == wait_d);
      npc       = next;
      #1;
      chk("wait_inst_valid", 32'(inst_valid), 32'd0);
      chk("wait_arvalid", 32'(arvalid), 32'd0);
      chk("wait_rready", 32'(rready), 32'd0);
      chk("wait_pc", pc, exp_pc);
      chk_perf();
      @(negedge clock);
    end
    npc_valid = 1'b0;
    exp_pc = next;
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    fetch(0, 0, 2'b00, 32'h0010_0093, 0);
    give_npc(0, 32'h8000_0004);
    fetch(5, 4, 2'b00, 32'h1234_5678, 0);
    give_npc(1, 32'h8000_0008);
    fetch(0, 0, 2'b10, 32'hDEAD_BEEF, 0);
    give_npc(0, 32'h8000_000C);
    fetch(0, 1, 2'b00, 32'hCAFE_0001, 6);
    give_npc(2, 32'h8000_0010);
    fetch(1, 0, 2'b00, 32'hCAFE_0002, 1);
    give_npc(0, 32'h8000_0006);
    fetch(0, 0, 2'b00, 32'hCAFE_0003, 0);
    give_npc(0, 32'hFFFF_FFFC);
    fetch(0, 0, 2'b11, 32'h0, 0);

    for (int k = 0; k < 25; k++) begin
      logic [1:0] rsp;
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      give_npc($urandom_range(0, 3), $urandom);
      fetch($urandom_range(0, 4), $urandom_range(0, 4), rsp, $urandom, $urandom_range(0, 4));
    end

    // Abandon a read mid-flight: reach the data phase, stall, then reset.
    give_npc(0, 32'h8000_0100);
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0; rvalid = 1'b0; #1;
    chk("mid_rready", 32'(rready), 32'd1);
    @(negedge clock);
    do_reset();
    fetch(0, 0, 2'b00, 32'h0000_0073, 0);
    give_npc(0, 32'h8000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_25010008_ifu.md
Name: ysyx_25010008_ifu

Overview:
- Instruction fetch unit of the multi-cycle core; it produces the `inst` word that the decoder consumes.
- Issues one 32-bit read per instruction on an AXI4-Lite read channel (AR/R only).
- Hands the fetched word plus its PC downstream with a valid/ready handshake.
- Waits for the next PC from write-back before starting the following fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- FAULT_INST, 32'h0000_0013, word presented on `inst` when the bus returns an error response (NOP).

Ports:
- clock  in  1  core clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- npc  in  32  next PC from write-back
- npc_valid  in  1  `npc` valid; sampled only in S_WAIT
- inst  out  32  fetched instruction to decoder
- pc  out  32  PC of `inst`
- inst_fault  out  1  bus error on this fetch; qualified by `inst_valid`
- inst_valid  out  1  `inst`/`pc`/`inst_fault` valid
- inst_ready  in  1  decoder accepts the instruction
- araddr  out  32  read address
- arvalid  out  1  read address valid
- arready  in  1  slave accepts address
- rdata  in  32  read data
- rresp  in  2  read response; 2'b00 = OKAY, anything else = error
- rvalid  in  1  read data valid
- rready  out  1  IFU accepts read data

Behaviour:
- Reset values (synchronous):
  - state = S_AR, pc = RESET_PC.
  - inst = 0, inst_fault = 0, inst_valid = 0.
  - arvalid = 0 and rready = 0 during the reset cycle.
  - First arvalid is driven in the first cycle with reset low.
- Output decode from state:
  - arvalid = (state == S_AR), araddr = {pc[31:2], 2'b00}.
  - rready = (state == S_R).
  - inst_valid = (state == S_OUT).
- State transitions:
  - S_AR: arvalid=1, araddr held stable until arready. On arvalid & arready -> S_R.
  - S_R: rready=1. On rvalid:
    - inst <= (rresp == 2'b00) ? rdata : FAULT_INST.
    - inst_fault <= (rresp != 2'b00).
    - -> S_OUT.
  - S_OUT: inst_valid=1. inst, pc and inst_fault are held constant until inst_ready. On inst_ready -> S_WAIT.
  - S_WAIT: all handshake outputs 0. On npc_valid: pc <= npc, -> S_AR.
- Minimum latency:
  - npc_valid in cycle t, with arready and rvalid asserted in the first cycle each is sampled.
  - inst_valid = 1 at cycle t+3.
  - First fetch after reset: inst_valid in the 3rd cycle after reset deasserts.
- Handshake rules:
  - Bus stalls (arready or rvalid low) hold the state indefinitely; there is no timeout.
  - inst_valid never drops without inst_ready.
- npc_valid outside S_WAIT is ignored and pc does not change.
- npc[1:0] != 0: the address is word-aligned on the bus, and `pc` reports npc unmodified.
- Only one outstanding read at any time; no prefetch.
- Reset mid-operation (any state): returns to the reset values above. Any in-flight bus beat is abandoned; the slave is reset by the same signal.
- pc/npc arithmetic is full 32-bit with no wrap check. RESET_PC + 4 etc. is computed upstream, not here.

Optional Feature:
- Macro: YSYX_25010008_IFU_PERF_EN.
- When defined, add output ports:
  - perf_fetch_cnt[31:0]: increments on each S_OUT -> S_WAIT transition.
  - perf_stall_cnt[31:0]: increments every cycle in S_AR with !arready, or in S_R with !rvalid.
  - Both counters clear to 0 on reset and wrap modulo 2^32.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then zero-wait slave returning 32'h0010_0093:
  - araddr=32'h8000_0000 on cycle 1.
  - inst_valid on cycle 3 with inst=32'h0010_0093, pc=32'h8000_0000, inst_fault=0.
- arready held low 5 cycles, then rvalid delayed 4 cycles:
  - araddr/arvalid stable throughout.
  - inst_valid only after rvalid.
  - PERF build: perf_stall_cnt=9.
- Slave returns rresp=2'b10, rdata=32'hDEAD_BEEF:
  - inst=32'h0000_0013, inst_fault=1.
- inst_ready held low 6 cycles with npc_valid pulsed meanwhile:
  - inst/pc stable, pulse ignored, no new arvalid.
  - After accept, npc_valid with npc=32'h8000_0010 -> next araddr=32'h8000_0010.
- npc=32'h8000_0006 -> araddr=32'h8000_0004, pc=32'h8000_0006.
- Assert reset while in S_R with rvalid low -> next cycle after release: arvalid=1, araddr=RESET_PC, inst_valid=0.
